// File: rtl/counter_run_arbiter.sv
// Two-requester round-robin arbiter that owns a shared up-counter and runs it
// from 0 to the winner's latched terminal value, then pulses done for one cycle.
module counter_run_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic             abort,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             last_q;
  logic [WIDTH-1:0] term_q;
  logic [WIDTH-1:0] count_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             busy_q;
  logic             done_q;

  logic             any_req;
  logic             win_d;
  logic [WIDTH-1:0] win_len_d;

  // Winner is only meaningful when any_req is high; ties go to whoever was not served last.
  always_comb begin
    any_req   = req0 | req1;
    win_d     = 1'b0;
    if (req0 && req1) begin
      win_d = ~last_q;
    end else begin
      win_d = ~req0;
    end
    win_len_d = win_d ? len1 : len0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      term_q  <= '0;
      count_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          count_q <= '0;
          done_q  <= 1'b0;
          if (any_req) begin
            state_q <= RUN;
            term_q  <= win_len_d;
            last_q  <= win_d;
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            busy_q  <= 1'b1;
          end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        RUN: begin
          // Abort takes priority over reaching the terminal count.
          if (abort) begin
            state_q <= IDLE;
            count_q <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (count_q == term_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            count_q <= count_q + WIDTH'(1);
          end
        end

        DONE: begin
          state_q <= IDLE;
          count_q <= '0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          count_q <= '0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = busy_q;
  assign done = done_q;
  assign Q    = count_q;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Scoreboard bench for counter_run_arbiter: a run-age reference model predicts the
// outputs after each clock edge and a monitor compares them against the DUT.
module tb_counter_run_arbiter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         req0, req1, abort;
  logic [W-1:0] len0, len1;
  logic         gnt0, gnt1, busy, done;
  logic [W-1:0] Q;

  counter_run_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .len0(len0), .len1(len1), .abort(abort),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .Q(Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         g0;
    logic         g1;
    logic         bz;
    logic         dn;
    logic [W-1:0] q;
    int           id;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model: who owns the counter, cycles elapsed since the grant, and the run length.
  int m_owner;
  int m_age;
  int m_term;
  int m_last;

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_term  = 0;
    m_last  = 1;
  endtask

  task automatic model_step(input bit r0, input bit r1, input int l0, input int l1, input bit ab);
    int w;
    if (m_owner < 0) begin
      if (r0 || r1) begin
        if (r0 && r1) w = (m_last == 1) ? 0 : 1;
        else          w = r0 ? 0 : 1;
        m_owner = w;
        m_term  = (w == 1) ? l1 : l0;
        m_age   = 0;
        m_last  = w;
      end
    end else if (m_age == m_term + 1) begin
      m_owner = -1;                 // the done cycle has been shown
    end else if (ab) begin
      m_owner = -1;
    end else begin
      m_age = m_age + 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.g0 = (m_owner == 0);
    e.g1 = (m_owner == 1);
    e.bz = (m_owner >= 0);
    e.dn = (m_owner >= 0) && (m_age == m_term + 1);
    e.q  = (m_owner < 0) ? '0 : W'((m_age > m_term) ? m_term : m_age);
    e.id = cyc;
    return e;
  endfunction

  task automatic check_now(input string name, input exp_t e);
    vectors = vectors + 1;
    if (gnt0 !== e.g0 || gnt1 !== e.g1 || busy !== e.bz || done !== e.dn || Q !== e.q) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got gnt=%b%b busy=%b done=%b Q=%0d, expected gnt=%b%b busy=%b done=%b Q=%0d",
               name, gnt1, gnt0, busy, done, Q, e.g1, e.g0, e.bz, e.dn, e.q);
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge and the prediction for
  // the following rising edge is queued for the monitor.
  task automatic cycle(input bit r0, input bit r1, input int l0, input int l1,
                       input bit ab, input bit rs);
    exp_t e;
    @(negedge clk);
    req0  = r0;
    req1  = r1;
    len0  = W'(l0);
    len1  = W'(l1);
    abort = ab;
    cyc   = cyc + 1;
    if (!rs) begin
      rst = 1'b0;
      model_reset();
      #1;
      e = model_out();
      check_now($sformatf("async_reset_c%0d", cyc), e);
    end else begin
      rst = 1'b1;
      model_step(r0, r1, l0, l1, ab);
    end
    e = model_out();
    $display("cyc %0d: rst=%b req=%b%b len0=%0d len1=%0d abort=%b -> expect gnt=%b%b Q=%0d done=%b",
             cyc, rs, r1, r0, l0, l1, ab, e.g1, e.g0, e.q, e.dn);
    exp_q.push_back(e);
  endtask

  // Monitor: compares the DUT against the oldest prediction shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now($sformatf("cycle_c%0d", e.id), e);
      end
    end
  end

  initial begin
    int l0r, l1r;
    bit r0r, r1r, abr, rsr;
    model_reset();
    rst = 1'b0; req0 = 0; req1 = 0; abort = 0; len0 = '0; len1 = '0;
    #2;
    begin
      exp_t z;
      z = model_out();
      check_now("reset_state", z);
    end
    repeat (2) cycle(0, 0, 0, 0, 0, 0);

    // Reset in the middle of a run at Q = 4, then a tie after release goes to requester 0.
    cycle(1, 0, 9, 0, 0, 1);
    repeat (4) cycle(1, 0, 9, 0, 0, 1);
    cycle(1, 0, 9, 0, 0, 0);
    cycle(1, 1, 3, 3, 0, 1);
    repeat (8) cycle(0, 0, 3, 3, 0, 1);

    // Single run of length 5 from a one-cycle request pulse.
    cycle(1, 0, 5, 0, 0, 1);
    repeat (9) cycle(0, 0, 5, 0, 0, 1);

    // Continuous contention, both lengths 2.
    repeat (22) cycle(1, 1, 2, 2, 0, 1);
    repeat (3) cycle(0, 0, 2, 2, 0, 1);

    // Zero-length and maximum-length runs on requester 1.
    cycle(0, 1, 0, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 15, 0, 1);
    repeat (20) cycle(0, 0, 0, 15, 0, 1);

    // Abort at Q = 3 with requester 1 pending.
    cycle(1, 0, 8, 4, 0, 1);
    for (int i = 0; i < 14; i++) begin
      cycle(0, 1, 8, 4, (m_owner == 0 && m_age == 3), 1);
    end
    repeat (4) cycle(0, 0, 8, 4, 0, 1);

    // Length changed after the grant must not affect the latched terminal value.
    cycle(0, 1, 0, 6, 0, 1);
    repeat (10) cycle(0, 0, 0, 1, 0, 1);

    // Abort presented in DONE is ignored.
    cycle(1, 0, 2, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 2, 0, (m_owner >= 0 && m_age == m_term + 1), 1);
    end

    // Randomized traffic with occasional aborts and asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      r0r = ($urandom_range(0, 2) != 0);
      r1r = ($urandom_range(0, 2) != 0);
      l0r = $urandom_range(0, 15);
      l1r = $urandom_range(0, 15);
      abr = ($urandom_range(0, 11) == 0);
      rsr = ($urandom_range(0, 149) != 0);
      cycle(r0r, r1r, l0r, l1r, abr, rsr);
    end
    repeat (3) cycle(0, 0, 0, 0, 0, 1);

    repeat (2) @(posedge clk);
    #3;
    vectors = vectors + 1;
    if (exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
